// File: rtl/poly_tone_synth_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : poly_tone_synth_if                                         |
// | Description : PS/2 byte input, audio FIFO handshake and status outputs   |
// |               of the polyphonic square-wave synthesizer.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface poly_tone_synth_if #(
   parameter int NUM_VOICES = 7,
   parameter int SAMPLE_W   = 32
);
   logic [7:0]                 ps2_byte;
   logic                       ps2_byte_valid;
   logic                       audio_out_allowed;
   logic signed [SAMPLE_W-1:0] left_channel_audio_out;
   logic signed [SAMPLE_W-1:0] right_channel_audio_out;
   logic                       write_audio_out;
   logic [NUM_VOICES-1:0]      voice_active;
   logic signed [3:0]          octave;
   logic [1:0]                 accidental;
   logic [7:0]                 last_byte;

   // Keyboard/FIFO side: drives the byte stream and handshake.
   modport master (
      output ps2_byte, ps2_byte_valid, audio_out_allowed,
      input  left_channel_audio_out, right_channel_audio_out, write_audio_out,
      input  voice_active, octave, accidental, last_byte
   );

   // Synthesizer side.
   modport slave (
      input  ps2_byte, ps2_byte_valid, audio_out_allowed,
      output left_channel_audio_out, right_channel_audio_out, write_audio_out,
      output voice_active, octave, accidental, last_byte
   );
endinterface
`default_nettype wire

// File: rtl/poly_tone_synth.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : poly_tone_synth                                            |
// | Description : PS/2 set-2 decoder driving up to seven square-wave voices, |
// |               mixed into a signed sample for the audio FIFO.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module poly_tone_synth #(
   parameter int NUM_VOICES = 7,
   parameter int SAMPLE_W   = 32,
   parameter int AMPLITUDE  = 10000000,
   parameter int OCT_MIN    = -4,
   parameter int OCT_MAX    = 4
) (
   input logic              CLOCK_50,
   input logic              reset,
   poly_tone_synth_if.slave bus
);

   localparam logic signed [SAMPLE_W-1:0] c_amp = SAMPLE_W'(AMPLITUDE);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXT     = 2'd1,
      S_BRK     = 2'd2,
      S_EXT_BRK = 2'd3
   } state_t;

   state_t                     state_q;
   logic [NUM_VOICES-1:0]      voice_active_q;
   logic signed [3:0]          octave_q;
   logic [1:0]                 accidental_q;
   logic [7:0]                 last_byte_q;
   logic [31:0]                inc_q [NUM_VOICES];
   logic [31:0]                acc_q [NUM_VOICES];
   logic [31:0]                acc_d [NUM_VOICES];
   logic signed [SAMPLE_W-1:0] mix_q;
   logic signed [SAMPLE_W-1:0] sample_q;
   logic                       write_q;

   logic                       w_note_hit;
   logic [2:0]                 w_note_idx;
   logic                       w_note_ok;
   logic                       w_note_on;
   logic [NUM_VOICES-1:0]      w_on_vec;
   logic signed [SAMPLE_W-1:0] w_voice_out [NUM_VOICES];
   logic signed [SAMPLE_W-1:0] w_mix;

   // Phase increment of each natural note at octave 0 (f * 2^32 / 50 MHz).
   function automatic logic [31:0] base_inc(input logic [2:0] idx);
      case (idx)
         3'd0:    return 32'd37796;
         3'd1:    return 32'd42434;
         3'd2:    return 32'd44925;
         3'd3:    return 32'd50423;
         3'd4:    return 32'd56608;
         3'd5:    return 32'd59958;
         3'd6:    return 32'd67345;
         default: return 32'd0;
      endcase
   endfunction

   // Octave shift first, then a fixed-point semitone up (17358/2^14) or down (15464/2^14).
   function automatic logic [31:0] calc_inc(input logic [2:0] idx,
                                            input logic signed [3:0] oct,
                                            input logic [1:0] accd);
      logic [31:0] base;
      logic [31:0] sh;
      logic [3:0]  mag;
      base = base_inc(idx);
      mag  = (oct < 0) ? 4'(-oct) : 4'(oct);
      if (oct > 0)
         sh = base << mag;
      else if (oct < 0)
         sh = base >> mag;
      else
         sh = base;
      case (accd)
         2'd1:    return 32'((64'(sh) * 64'd17358) >> 14);
         2'd2:    return 32'((64'(sh) * 64'd15464) >> 14);
         default: return sh;
      endcase
   endfunction

   // Map a set-2 scan code onto its voice index; codes past NUM_VOICES are not notes.
   always_comb begin
      w_note_hit = 1'b1;
      w_note_idx = 3'd0;
      case (bus.ps2_byte)
         8'h16:   w_note_idx = 3'd0;
         8'h1E:   w_note_idx = 3'd1;
         8'h26:   w_note_idx = 3'd2;
         8'h25:   w_note_idx = 3'd3;
         8'h2E:   w_note_idx = 3'd4;
         8'h36:   w_note_idx = 3'd5;
         8'h3D:   w_note_idx = 3'd6;
         default: w_note_hit = 1'b0;
      endcase
      w_note_ok = w_note_hit && (int'(w_note_idx) < NUM_VOICES);
      w_note_on = bus.ps2_byte_valid && (state_q == S_IDLE) && w_note_ok &&
                  !voice_active_q[w_note_idx];
      w_on_vec  = '0;
      if (w_note_on)
         w_on_vec[w_note_idx] = 1'b1;
   end

   // Scan-sequence decoder: owns note state, tuning of new notes, octave and accidental.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q        <= S_IDLE;
         voice_active_q <= '0;
         octave_q       <= 4'sd0;
         accidental_q   <= 2'd0;
         last_byte_q    <= 8'h00;
         for (int v = 0; v < NUM_VOICES; v++)
            inc_q[v] <= '0;
      end else if (bus.ps2_byte_valid) begin
         last_byte_q <= bus.ps2_byte;
         case (state_q)
            S_IDLE: begin
               if (bus.ps2_byte == 8'hE0)
                  state_q <= S_EXT;
               else if (bus.ps2_byte == 8'hF0)
                  state_q <= S_BRK;
               else begin
                  state_q <= S_IDLE;
                  // Typematic repeats of a held key fall out here: w_note_on is low.
                  if (w_note_on) begin
                     voice_active_q[w_note_idx] <= 1'b1;
                     inc_q[w_note_idx]          <= calc_inc(w_note_idx, octave_q, accidental_q);
                  end
               end
            end
            S_EXT: begin
               if (bus.ps2_byte == 8'hF0)
                  state_q <= S_EXT_BRK;
               else begin
                  state_q <= S_IDLE;
                  case (bus.ps2_byte)
                     8'h75: if (int'(octave_q) < OCT_MAX) octave_q <= octave_q + 4'sd1;
                     8'h72: if (int'(octave_q) > OCT_MIN) octave_q <= octave_q - 4'sd1;
                     8'h6B: accidental_q <= (accidental_q == 2'd2) ? 2'd0 : 2'd2;
                     8'h74: accidental_q <= (accidental_q == 2'd1) ? 2'd0 : 2'd1;
                     default: ;
                  endcase
               end
            end
            S_BRK: begin
               state_q <= S_IDLE;
               if (w_note_ok)
                  voice_active_q[w_note_idx] <= 1'b0;
            end
            S_EXT_BRK: state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   // Next phase: restart on note-on, advance while held, otherwise freeze.
   always_comb begin
      for (int v = 0; v < NUM_VOICES; v++) begin
         acc_d[v] = acc_q[v];
         if (w_on_vec[v])
            acc_d[v] = '0;
         else if (voice_active_q[v])
            acc_d[v] = acc_q[v] + inc_q[v];
      end
   end

   // Phase accumulator registers.
   always_ff @(posedge CLOCK_50) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
         if (reset)
            acc_q[v] <= '0;
         else
            acc_q[v] <= acc_d[v];
      end
   end

   generate
      for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
         assign w_voice_out[v] = !voice_active_q[v] ? '0 :
                                 (acc_q[v][31] ? -c_amp : c_amp);
      end
   endgenerate

   // Sum of all voices; cannot overflow for legal NUM_VOICES * AMPLITUDE.
   always_comb begin
      w_mix = '0;
      for (int v = 0; v < NUM_VOICES; v++)
         w_mix = w_mix + w_voice_out[v];
   end

   // Mix register and FIFO handshake: the sample only moves when a write is issued.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         mix_q    <= '0;
         sample_q <= '0;
         write_q  <= 1'b0;
      end else begin
         mix_q   <= w_mix;
         write_q <= bus.audio_out_allowed;
         if (bus.audio_out_allowed)
            sample_q <= mix_q;
      end
   end

   assign bus.left_channel_audio_out  = sample_q;
   assign bus.right_channel_audio_out = sample_q;
   assign bus.write_audio_out         = write_q;
   assign bus.voice_active            = voice_active_q;
   assign bus.octave                  = octave_q;
   assign bus.accidental              = accidental_q;
   assign bus.last_byte               = last_byte_q;

endmodule
`default_nettype wire

// File: tb/tb_poly_tone_synth.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_poly_tone_synth                                         |
// | Description : Directed stimulus with a cycle-level reference model and   |
// |               literal spot checks for poly_tone_synth.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_poly_tone_synth;

   localparam int NV  = 7;
   localparam int SW  = 32;
   localparam int AMP = 10000000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   bit   started = 1'b0;

   always #5 clk = ~clk;

   poly_tone_synth_if #(.NUM_VOICES(NV), .SAMPLE_W(SW)) bus ();

   poly_tone_synth #(
      .NUM_VOICES(NV), .SAMPLE_W(SW), .AMPLITUDE(AMP), .OCT_MIN(-4), .OCT_MAX(4)
   ) dut (
      .CLOCK_50(clk),
      .reset   (rst),
      .bus     (bus)
   );

   // ---------------- reference model ----------------
   int unsigned base_tab [NV] = '{37796, 42434, 44925, 50423, 56608, 59958, 67345};
   byte unsigned code_tab [NV] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D};

   bit           m_active [NV];
   int unsigned  m_phase  [NV];
   int unsigned  m_inc    [NV];
   int           m_oct;
   int           m_accd;
   byte unsigned m_last;
   longint       m_mix;
   longint       m_left;
   bit           m_wr;
   byte unsigned pfx [$];

   function automatic int unsigned model_inc(int v, int oct, int accd);
      longint unsigned s;
      s = base_tab[v];
      if (oct > 0) s = s << oct;
      else if (oct < 0) s = s >> (-oct);
      if (accd == 1) s = (s * 17358) / 16384;
      else if (accd == 2) s = (s * 15464) / 16384;
      return 32'(s);
   endfunction

   function automatic int note_voice(byte unsigned b);
      for (int i = 0; i < NV; i++)
         if (code_tab[i] == b) return i;
      return -1;
   endfunction

   function automatic logic [NV-1:0] model_active_vec();
      logic [NV-1:0] r;
      for (int i = 0; i < NV; i++) r[i] = m_active[i];
      return r;
   endfunction

   function automatic void model_byte(byte unsigned b);
      int v;
      m_last = b;
      v = note_voice(b);
      if (pfx.size() == 0) begin
         if (b == 8'hE0 || b == 8'hF0) pfx.push_back(b);
         else if (v >= 0 && !m_active[v]) begin
            m_active[v] = 1'b1;
            m_phase[v]  = 0;
            m_inc[v]    = model_inc(v, m_oct, m_accd);
         end
      end else if (pfx.size() == 1 && pfx[0] == 8'hE0) begin
         if (b == 8'hF0) pfx.push_back(b);
         else begin
            pfx.delete();
            case (b)
               8'h75: if (m_oct < 4)  m_oct = m_oct + 1;
               8'h72: if (m_oct > -4) m_oct = m_oct - 1;
               8'h6B: m_accd = (m_accd == 2) ? 0 : 2;
               8'h74: m_accd = (m_accd == 1) ? 0 : 1;
               default: ;
            endcase
         end
      end else if (pfx[0] == 8'hF0) begin
         if (v >= 0) m_active[v] = 1'b0;
         pfx.delete();
      end else begin
         pfx.delete();
      end
   endfunction

   always @(posedge clk) begin
      longint s;
      if (rst) begin
         for (int i = 0; i < NV; i++) begin
            m_active[i] = 1'b0; m_phase[i] = 0; m_inc[i] = 0;
         end
         m_oct = 0; m_accd = 0; m_last = 0; m_mix = 0; m_left = 0; m_wr = 0;
         pfx.delete();
      end else begin
         if (bus.audio_out_allowed) m_left = m_mix;
         m_wr = bus.audio_out_allowed;
         s = 0;
         for (int i = 0; i < NV; i++)
            if (m_active[i]) s += m_phase[i][31] ? -AMP : AMP;
         m_mix = s;
         for (int i = 0; i < NV; i++)
            if (m_active[i]) m_phase[i] = m_phase[i] + m_inc[i];
         if (bus.ps2_byte_valid) model_byte(bus.ps2_byte);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         check("left",       bus.left_channel_audio_out,  m_left);
         check("right",      bus.right_channel_audio_out, m_left);
         check("write",      {63'd0, bus.write_audio_out}, {63'd0, m_wr});
         check("active",     {57'd0, bus.voice_active},    {57'd0, model_active_vec()});
         check("octave",     bus.octave,                   m_oct);
         check("accidental", {62'd0, bus.accidental},      m_accd);
         check("last_byte",  {56'd0, bus.last_byte},       {56'd0, m_last});
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      bus.ps2_byte       = b;
      bus.ps2_byte_valid = 1'b1;
      @(negedge clk);
      bus.ps2_byte_valid = 1'b0;
      bus.ps2_byte       = 8'h00;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bus.ps2_byte = 8'h00; bus.ps2_byte_valid = 1'b0; bus.audio_out_allowed = 1'b0;
      idle(2);
      rst = 1'b0;
      @(posedge clk);
      started = 1'b1;

      // Reset in the middle of an extended sequence.
      send(8'hE0);
      rst = 1'b1;
      idle(3);
      rst = 1'b0;
      check("rst_left",   bus.left_channel_audio_out, 0);
      check("rst_write",  {63'd0, bus.write_audio_out}, 0);
      check("rst_active", {57'd0, bus.voice_active}, 0);
      check("rst_octave", bus.octave, 0);
      check("rst_last",   {56'd0, bus.last_byte}, 0);
      send(8'h75);
      check("discard_prefix_octave", bus.octave, 0);
      check("discard_prefix_last", {56'd0, bus.last_byte}, 8'h75);

      // Single note A and its first half-period.
      bus.audio_out_allowed = 1'b1;
      send(8'h16);
      check("noteA_active", {57'd0, bus.voice_active}, 1);
      check("noteA_model_inc", {32'd0, m_inc[0]}, 37796);
      cnt = 0;
      while (bus.left_channel_audio_out != AMP && cnt < 10) begin
         cnt++;
         @(negedge clk);
      end
      check("noteA_high", bus.left_channel_audio_out, AMP);
      cnt = 0;
      while (bus.left_channel_audio_out == AMP && cnt < 60000) begin
         cnt++;
         @(negedge clk);
      end
      check("noteA_halfperiod", cnt, 56818);
      check("noteA_low", bus.left_channel_audio_out, -AMP);
      send(8'hF0); send(8'h16);
      idle(3);
      check("noteA_off_active", {57'd0, bus.voice_active}, 0);
      check("noteA_off_left", bus.left_channel_audio_out, 0);

      // Chord with a typematic repeat of A, then release C.
      send(8'h16); send(8'h26);
      idle(50);
      send(8'h16);
      idle(200);
      send(8'hF0); send(8'h26);
      idle(20);
      check("chord_active", {57'd0, bus.voice_active}, 7'b0000001);
      check("chord_mag", (bus.left_channel_audio_out < 0) ?
                         -bus.left_channel_audio_out : bus.left_channel_audio_out, AMP);

      // Octave saturation, sharp, retune only on fresh note-on.
      repeat (5) begin send(8'hE0); send(8'h75); end
      check("oct_sat", bus.octave, 4);
      send(8'hE0); send(8'h74);
      check("sharp_on", {62'd0, bus.accidental}, 1);
      send(8'hF0); send(8'h16);
      send(8'h16);
      check("sharpA_model_inc", {32'd0, m_inc[0]}, 640686);
      idle(3400);
      send(8'hE0); send(8'h74);
      check("sharp_off", {62'd0, bus.accidental}, 0);
      idle(3400);

      // Ignored sequences.
      send(8'hE0); send(8'hF0); send(8'h75);
      check("ext_brk_octave", bus.octave, 4);
      send(8'hF0); send(8'h1C);
      check("brk_undef_active", {57'd0, bus.voice_active}, 1);
      send(8'h1C);
      check("undef_last", {56'd0, bus.last_byte}, 8'h1C);
      check("undef_active", {57'd0, bus.voice_active}, 1);

      // Octave down, flat, a second voice.
      send(8'hE0); send(8'h72);
      check("oct_down", bus.octave, 3);
      send(8'hE0); send(8'h6B);
      check("flat_on", {62'd0, bus.accidental}, 2);
      send(8'h25);
      check("noteD_active", {57'd0, bus.voice_active}, 7'b0001001);
      idle(500);
      send(8'hE0); send(8'h6B);
      check("flat_off", {62'd0, bus.accidental}, 0);
      send(8'hF0); send(8'h25);
      idle(10);

      // Handshake latency and sample hold.
      bus.audio_out_allowed = 1'b0; @(negedge clk);
      check("hs0", {63'd0, bus.write_audio_out}, 0);
      bus.audio_out_allowed = 1'b1; @(negedge clk);
      check("hs1", {63'd0, bus.write_audio_out}, 1);
      bus.audio_out_allowed = 1'b0; @(negedge clk);
      check("hs2", {63'd0, bus.write_audio_out}, 0);
      bus.audio_out_allowed = 1'b0; @(negedge clk);
      check("hs3", {63'd0, bus.write_audio_out}, 0);
      bus.audio_out_allowed = 1'b1; @(negedge clk);
      check("hs4", {63'd0, bus.write_audio_out}, 1);
      bus.audio_out_allowed = 1'b0;
      idle(300);
      bus.audio_out_allowed = 1'b1;
      idle(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
